// File: rtl/ntt_engine.sv
// ntt_engine: in-place radix-2 DIT NTT/INTT over Z_Q with one butterfly and run-time twiddles.
// Words load in natural order (stored bit-reversed), are transformed, optionally scaled by 1/N, and unload in natural order.
module ntt_engine #(
  parameter int LOG_N    = 3,
  parameter int W        = 5,
  parameter int Q        = 17,
  parameter int ROOT     = 2,
  parameter int ROOT_INV = 9,
  parameter int N_INV    = 15
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         op,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);
  localparam int N  = 1 << LOG_N;
  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  localparam logic [W-1:0]     QW       = W'(Q);
  localparam logic [2*W-1:0]   Q2       = (2*W)'(Q);
  localparam logic [W-1:0]     ONE      = W'(1);
  localparam logic [W-1:0]     ROOT_W   = W'(ROOT);
  localparam logic [W-1:0]     RINV_W   = W'(ROOT_INV);
  localparam logic [W-1:0]     NINV_W   = W'(N_INV);
  localparam logic [LOG_N-1:0] CNT_ONE  = LOG_N'(1);
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] PREP_END = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-2:0] BF_ONE   = (LOG_N-1)'(1);
  localparam logic [LOG_N-2:0] BF_LAST  = (LOG_N-1)'(N/2 - 1);
  localparam logic [SW-1:0]    STG_ONE  = SW'(1);
  localparam logic [SW-1:0]    STG_LAST = SW'(LOG_N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PREP, COMP, SCALE, UNLOAD} state_t;

  state_t           state, state_nxt;
  logic             op_q;
  logic [LOG_N-1:0] cnt;
  logic [LOG_N-2:0] bfly;
  logic [SW-1:0]    stage;
  logic [W-1:0]     w;
  logic [W-1:0]     sq_q;
  logic [W-1:0]     wm  [LOG_N];
  logic [W-1:0]     mem [N];

  logic [LOG_N-1:0] half, lo_mask, bf_ext, i_lo, i_hi;
  logic [W-1:0]     t, bf_sum, bf_dif, tw_next, root_sel;
  logic [SW-1:0]    wm_idx;
  logic             grp_end;

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(p % Q2);
  endfunction

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return s[W-1:0];
  endfunction

  // Both operands are < Q, so x + (Q - y) cannot overflow W bits when x < y.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? (x - y) : (x + (QW - y));
  endfunction

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
    logic [LOG_N-1:0] r;
    for (int b = 0; b < LOG_N; b++) r[b] = x[LOG_N-1-b];
    return r;
  endfunction

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign busy      = (state != IDLE);
  assign out_data  = (state == UNLOAD) ? mem[cnt] : '0;

  // Butterfly pair for index bfly in stage: low bits stay, high bits shift up past the half-span bit.
  always_comb begin
    half     = CNT_ONE << stage;
    lo_mask  = half - CNT_ONE;
    bf_ext   = {1'b0, bfly};
    i_lo     = ((bf_ext & ~lo_mask) << 1) | (bf_ext & lo_mask);
    i_hi     = i_lo | half;
    grp_end  = ((bf_ext & lo_mask) == lo_mask);
    t        = mod_mul(w, mem[i_hi]);
    bf_sum   = mod_add(mem[i_lo], t);
    bf_dif   = mod_sub(mem[i_lo], t);
    root_sel = op_q ? RINV_W : ROOT_W;
    tw_next  = (cnt == '0) ? root_sel : mod_mul(sq_q, sq_q);
    wm_idx   = STG_LAST - SW'(cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (in_valid && cnt == LAST_IDX) state_nxt = PREP;
      PREP:    if (cnt == PREP_END) state_nxt = COMP;
      COMP:    if (stage == STG_LAST && bfly == BF_LAST) state_nxt = op_q ? SCALE : UNLOAD;
      SCALE:   if (cnt == LAST_IDX) state_nxt = UNLOAD;
      UNLOAD:  if (out_ready && cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      op_q  <= 1'b0;
      cnt   <= '0;
      bfly  <= '0;
      stage <= '0;
      w     <= ONE;
      sq_q  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == UNLOAD) && out_ready && (cnt == LAST_IDX);
      case (state)
        IDLE: begin
          cnt   <= '0;
          bfly  <= '0;
          stage <= '0;
          w     <= ONE;
          if (start) op_q <= op;
        end
        LOAD:   if (in_valid) cnt <= cnt + CNT_ONE;
        PREP: begin
          sq_q <= tw_next;
          cnt  <= (cnt == PREP_END) ? '0 : cnt + CNT_ONE;
        end
        COMP: begin
          bfly <= bfly + BF_ONE;
          if (bfly == BF_LAST) stage <= stage + STG_ONE;
          w <= grp_end ? ONE : mod_mul(w, wm[stage]);
        end
        SCALE:  cnt <= cnt + CNT_ONE;
        UNLOAD: if (out_ready) cnt <= cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

  // Coefficient buffer and twiddle table carry no reset; every word is rewritten before use.
  always_ff @(posedge clk) begin
    if (state == PREP) wm[wm_idx] <= tw_next;
    case (state)
      LOAD:  if (in_valid) mem[bitrev(cnt)] <= in_data;
      COMP: begin
        mem[i_lo] <= bf_sum;
        mem[i_hi] <= bf_dif;
      end
      SCALE: mem[cnt] <= mod_mul(mem[cnt], NINV_W);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ntt_engine.sv
// Bench for ntt_engine: randomized vectors against a direct O(N^2) DFT-over-Z_Q model.
module tb_ntt_engine;
  localparam int LOG_N    = 3;
  localparam int W        = 5;
  localparam int Q        = 17;
  localparam int ROOT     = 2;
  localparam int ROOT_INV = 9;
  localparam int N_INV    = 15;
  localparam int N        = 1 << LOG_N;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy, done;
  logic [W-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int xin [N];
  int expv[N];
  int res [N];
  int orig[N];

  always #5 clk = ~clk;

  ntt_engine #(
    .LOG_N(LOG_N), .W(W), .Q(Q), .ROOT(ROOT), .ROOT_INV(ROOT_INV), .N_INV(N_INV)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pw(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // X[k] = sum_j x[j] * r^(jk) mod Q, scaled by N^-1 for the inverse.
  task automatic model(input bit opv);
    int r, acc;
    r = opv ? ROOT_INV : ROOT;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int j = 0; j < N; j++) acc = (acc + xin[j] * pw(r, (j * k) % N)) % Q;
      if (opv) acc = (acc * N_INV) % Q;
      expv[k] = acc;
    end
  endtask

  task automatic rand_ctl(input bit stress);
    if (stress) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_start(input bit opv);
    start = 1'b1;
    op    = opv;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("in_ready_first_load", int'(in_ready), 1);
  endtask

  task automatic load(input bit stress);
    int j, cyc;
    bit hs;
    j = 0;
    cyc = 0;
    while (j < N && cyc < 500) begin
      in_valid = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = W'(xin[j]);
      rand_ctl(stress);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) j++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("load_words", j, N);
  endtask

  task automatic wait_out(input bit opv, input bit stress);
    int lat;
    lat = 0;
    while (!out_valid && lat < 500) begin
      rand_ctl(stress);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (opv) check("latency_intt", lat, LOG_N + LOG_N * N / 2 + N);
    else     check("latency_ntt", lat, LOG_N + LOG_N * N / 2);
  endtask

  task automatic unload(input bit stress, input string tag);
    int k, cyc, held;
    bit hs, stalled;
    k = 0;
    cyc = 0;
    held = 0;
    stalled = 1'b0;
    while (k < N && cyc < 500) begin
      if (stalled) begin
        check("stall_data_hold", int'(out_data), held);
        check("stall_valid_hold", int'(out_valid), 1);
      end
      out_ready = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
      rand_ctl(stress);
      hs = out_valid && out_ready;
      if (hs) begin
        res[k] = int'(out_data);
        check(tag, int'(out_data), expv[k]);
        k++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held    = int'(out_data);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("unload_words", k, N);
    check("done_pulse", int'(done), 1);
    check("busy_with_done", int'(busy), 0);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
  endtask

  task automatic run(input bit opv, input bit stress, input string tag);
    model(opv);
    do_start(opv);
    load(stress);
    wait_out(opv, stress);
    unload(stress, tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit opv;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (xin[i]) xin[i] = (i == 0) ? 1 : 0;
    run(1'b0, 1'b0, "impulse");
    foreach (xin[i]) xin[i] = 1;
    run(1'b0, 1'b0, "constant");
    foreach (xin[i]) xin[i] = (i == 1) ? 1 : 0;
    run(1'b0, 1'b0, "shift_ntt");
    foreach (xin[i]) xin[i] = res[i];
    run(1'b1, 1'b0, "shift_intt");
    check("shift_rt_x1", res[1], 1);

    for (int it = 0; it < 200; it++) begin
      foreach (xin[i]) begin
        xin[i]  = int'($urandom_range(0, Q - 1));
        orig[i] = xin[i];
      end
      run(1'b0, 1'b0, "rt_ntt");
      foreach (xin[i]) xin[i] = res[i];
      run(1'b1, 1'b0, "rt_intt");
      foreach (res[i]) check("rt_orig", res[i], orig[i]);
    end

    for (int it = 0; it < 24; it++) begin
      opv = 1'($urandom_range(0, 1));
      foreach (xin[i]) xin[i] = int'($urandom_range(0, Q - 1));
      run(opv, 1'b1, "stress");
    end

    foreach (xin[i]) xin[i] = int'($urandom_range(0, Q - 1));
    do_start(1'b0);
    load(1'b0);
    repeat (LOG_N + LOG_N * N / 4) @(posedge clk);
    #1;
    check("busy_in_comp", int'(busy), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rst_comp_busy", int'(busy), 0);
    check("rst_comp_out_valid", int'(out_valid), 0);
    check("rst_comp_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    foreach (xin[i]) xin[i] = (i == 0) ? 1 : 0;
    run(1'b0, 1'b0, "post_reset_impulse");
    foreach (res[i]) check("post_reset_ones", res[i], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
